// File: rtl/bp_fe_cache_req_arbiter.sv
// Shares the I$ engine request port between the demand miss path and a next-line prefetcher.
// An owner FSM follows the granted request through metadata and fill and routes completions back to it.
module bp_fe_cache_req_arbiter #(
    parameter int unsigned req_width_p      = 64,
    parameter int unsigned metadata_width_p = 8,
    parameter int unsigned req_id_width_p   = 1,
    parameter int unsigned pftch_gap_p      = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [req_width_p-1:0]      demand_req_i,
    input  logic                        demand_req_v_i,
    output logic                        demand_req_yumi_o,
    input  logic [metadata_width_p-1:0] demand_req_metadata_i,
    input  logic                        demand_req_metadata_v_i,
    output logic                        demand_req_critical_o,
    output logic                        demand_req_last_o,

    input  logic [req_width_p-1:0]      pftch_req_i,
    input  logic                        pftch_req_v_i,
    output logic                        pftch_req_yumi_o,
    input  logic [metadata_width_p-1:0] pftch_req_metadata_i,
    input  logic                        pftch_req_metadata_v_i,
    output logic                        pftch_req_critical_o,
    output logic                        pftch_req_last_o,

    output logic [req_width_p-1:0]      cache_req_o,
    output logic                        cache_req_v_o,
    input  logic                        cache_req_yumi_i,
    input  logic                        cache_req_lock_i,
    output logic [metadata_width_p-1:0] cache_req_metadata_o,
    output logic                        cache_req_metadata_v_o,
    input  logic [req_id_width_p-1:0]   cache_req_id_i,
    input  logic                        cache_req_critical_i,
    input  logic                        cache_req_last_i,
    input  logic                        cache_req_credits_empty_i,

    output logic [req_id_width_p-1:0]   req_id_o,
    output logic                        owner_pftch_o
);

    // The accept cycle counts as the first cooldown cycle, so the counter is loaded with gap-1.
    localparam int unsigned cd_width_lp = (pftch_gap_p > 2) ? $clog2(pftch_gap_p) : 1;
    localparam int unsigned cd_load_lp  = (pftch_gap_p > 0) ? pftch_gap_p - 1 : 0;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_meta  = 2'd1,
        e_busy  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   owner_pftch_q, owner_pftch_d;
    logic [cd_width_lp-1:0] cooldown_q, cooldown_d;
    logic                   pftch_eligible;

    assign req_id_o      = cache_req_id_i;
    assign owner_pftch_o = owner_pftch_q;

    assign pftch_eligible = pftch_req_v_i & ~demand_req_v_i & ~cache_req_lock_i
                          & cache_req_credits_empty_i & (cooldown_q == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= e_ready;
            owner_pftch_q <= 1'b0;
            cooldown_q    <= '0;
        end else begin
            state_q       <= state_d;
            owner_pftch_q <= owner_pftch_d;
            cooldown_q    <= cooldown_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        owner_pftch_d          = owner_pftch_q;
        cooldown_d             = (cooldown_q != '0) ? cooldown_q - cd_width_lp'(1) : '0;
        cache_req_o            = '0;
        cache_req_v_o          = 1'b0;
        cache_req_metadata_o   = '0;
        cache_req_metadata_v_o = 1'b0;
        demand_req_yumi_o      = 1'b0;
        pftch_req_yumi_o       = 1'b0;
        demand_req_critical_o  = 1'b0;
        demand_req_last_o      = 1'b0;
        pftch_req_critical_o   = 1'b0;
        pftch_req_last_o       = 1'b0;

        // Completion strobes only reach whoever owns the in-flight transaction.
        if (state_q != e_ready) begin
            demand_req_critical_o = ~owner_pftch_q & cache_req_critical_i;
            demand_req_last_o     = ~owner_pftch_q & cache_req_last_i;
            pftch_req_critical_o  =  owner_pftch_q & cache_req_critical_i;
            pftch_req_last_o      =  owner_pftch_q & cache_req_last_i;
        end

        case (state_q)
            e_ready: begin
                if (demand_req_v_i) begin
                    cache_req_o   = demand_req_i;
                    cache_req_v_o = 1'b1;
                    if (cache_req_yumi_i) begin
                        demand_req_yumi_o = 1'b1;
                        owner_pftch_d     = 1'b0;
                        state_d           = e_meta;
                    end
                end else if (pftch_eligible) begin
                    cache_req_o   = pftch_req_i;
                    cache_req_v_o = 1'b1;
                    if (cache_req_yumi_i) begin
                        pftch_req_yumi_o = 1'b1;
                        owner_pftch_d    = 1'b1;
                        cooldown_d       = cd_width_lp'(cd_load_lp);
                        state_d          = e_meta;
                    end
                end
            end
            e_meta: begin
                cache_req_metadata_o   = owner_pftch_q ? pftch_req_metadata_i : demand_req_metadata_i;
                cache_req_metadata_v_o = owner_pftch_q ? pftch_req_metadata_v_i : demand_req_metadata_v_i;
                state_d                = cache_req_last_i ? e_ready : e_busy;
            end
            e_busy: begin
                if (cache_req_last_i) begin
                    state_d = e_ready;
                end
            end
            default: begin
                state_d = e_ready;
            end
        endcase
    end

    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
        cache_req_yumi_i |-> cache_req_v_o);
    a_one_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
        !(demand_req_yumi_o && pftch_req_yumi_o));

endmodule

// File: tb/tb_bp_fe_cache_req_arbiter.sv
// Randomized and directed bench for bp_fe_cache_req_arbiter against a transaction-level
// reference model that tracks the in-flight owner and the cycle of the last prefetch grant.
module tb_bp_fe_cache_req_arbiter;

    localparam int unsigned REQ_W  = 64;
    localparam int unsigned META_W = 8;
    localparam int unsigned ID_W   = 1;
    localparam int unsigned GAP    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [REQ_W-1:0]  demand_req, pftch_req, cache_req;
    logic              demand_v, pftch_v, demand_yumi, pftch_yumi;
    logic [META_W-1:0] demand_meta, pftch_meta, cache_meta;
    logic              demand_meta_v, pftch_meta_v, cache_meta_v;
    logic              demand_crit, demand_last, pftch_crit, pftch_last;
    logic              cache_v, cache_yumi, lock, critical, last, credits_empty;
    logic [ID_W-1:0]   cache_id, req_id;
    logic              owner_pftch;

    bp_fe_cache_req_arbiter #(
        .req_width_p(REQ_W), .metadata_width_p(META_W),
        .req_id_width_p(ID_W), .pftch_gap_p(GAP)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .demand_req_i(demand_req), .demand_req_v_i(demand_v), .demand_req_yumi_o(demand_yumi),
        .demand_req_metadata_i(demand_meta), .demand_req_metadata_v_i(demand_meta_v),
        .demand_req_critical_o(demand_crit), .demand_req_last_o(demand_last),
        .pftch_req_i(pftch_req), .pftch_req_v_i(pftch_v), .pftch_req_yumi_o(pftch_yumi),
        .pftch_req_metadata_i(pftch_meta), .pftch_req_metadata_v_i(pftch_meta_v),
        .pftch_req_critical_o(pftch_crit), .pftch_req_last_o(pftch_last),
        .cache_req_o(cache_req), .cache_req_v_o(cache_v), .cache_req_yumi_i(cache_yumi),
        .cache_req_lock_i(lock), .cache_req_metadata_o(cache_meta),
        .cache_req_metadata_v_o(cache_meta_v), .cache_req_id_i(cache_id),
        .cache_req_critical_i(critical), .cache_req_last_i(last),
        .cache_req_credits_empty_i(credits_empty),
        .req_id_o(req_id), .owner_pftch_o(owner_pftch)
    );

    // Reference model: is a transaction in flight, is this its first cycle, who owns it,
    // and the cycle number of the most recent prefetch grant.
    bit m_txn, m_first, m_owner_pf;
    int cyc, m_last_pf;
    int n_checks, n_errors;

    // Sampled DUT outputs of the most recent tick, for directed checks.
    logic             s_v, s_dy, s_py, s_dc, s_dl, s_pc, s_pl;
    logic [REQ_W-1:0] s_req;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_in(input bit dv, input bit pv, input bit lk, input bit ce,
                          input bit cr, input bit la);
        demand_v      = dv;
        pftch_v       = pv;
        lock          = lk;
        credits_empty = ce;
        critical      = cr;
        last          = la;
        demand_req    = {$urandom, $urandom};
        pftch_req     = {$urandom, $urandom};
        demand_meta   = META_W'($urandom);
        pftch_meta    = META_W'($urandom);
        demand_meta_v = 1'b1;
        pftch_meta_v  = 1'b1;
        cache_id      = ID_W'($urandom);
    endtask

    // One clock: predict, drive yumi, compare, advance model on the edge.
    task automatic tick(input bit want_yumi);
        bit               pf_ok, e_v, e_dsel, e_psel, e_mv, yumi;
        bit               e_dc, e_dl, e_pc, e_pl;
        logic [REQ_W-1:0] e_req;
        logic [META_W-1:0] e_meta;
        pf_ok  = pftch_v && !demand_v && !lock && credits_empty && ((cyc - m_last_pf) >= int'(GAP));
        e_v = 0; e_dsel = 0; e_psel = 0; e_mv = 0; e_req = '0; e_meta = '0;
        e_dc = 0; e_dl = 0; e_pc = 0; e_pl = 0;
        if (!m_txn) begin
            if (demand_v) begin e_v = 1; e_req = demand_req; e_dsel = 1; end
            else if (pf_ok) begin e_v = 1; e_req = pftch_req; e_psel = 1; end
        end else begin
            if (m_first) begin
                e_mv   = m_owner_pf ? pftch_meta_v : demand_meta_v;
                e_meta = m_owner_pf ? pftch_meta : demand_meta;
            end
            e_dc = !m_owner_pf && critical;
            e_dl = !m_owner_pf && last;
            e_pc =  m_owner_pf && critical;
            e_pl =  m_owner_pf && last;
        end
        yumi = want_yumi && e_v && !reset;
        cache_yumi = yumi;
        #1;
        check_eq("v", 64'(cache_v), 64'(e_v));
        if (e_v) check_eq("req", 64'(cache_req), 64'(e_req));
        check_eq("meta_v", 64'(cache_meta_v), 64'(e_mv));
        check_eq("meta", 64'(cache_meta), 64'(e_meta));
        check_eq("demand_yumi", 64'(demand_yumi), 64'(yumi && e_dsel));
        check_eq("pftch_yumi", 64'(pftch_yumi), 64'(yumi && e_psel));
        check_eq("demand_crit", 64'(demand_crit), 64'(e_dc));
        check_eq("demand_last", 64'(demand_last), 64'(e_dl));
        check_eq("pftch_crit", 64'(pftch_crit), 64'(e_pc));
        check_eq("pftch_last", 64'(pftch_last), 64'(e_pl));
        check_eq("owner", 64'(owner_pftch), 64'(m_owner_pf));
        check_eq("req_id", 64'(req_id), 64'(cache_id));
        s_v = cache_v; s_dy = demand_yumi; s_py = pftch_yumi; s_req = cache_req;
        s_dc = demand_crit; s_dl = demand_last; s_pc = pftch_crit; s_pl = pftch_last;
        @(posedge clk);
        if (reset) begin
            m_txn = 0; m_first = 0; m_owner_pf = 0; m_last_pf = -1000;
        end else if (!m_txn) begin
            if (yumi) begin
                m_txn = 1; m_first = 1; m_owner_pf = e_psel;
                if (e_psel) m_last_pf = cyc;
            end
        end else begin
            m_first = 0;
            if (last) m_txn = 0;
        end
        cyc++;
        #1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        m_txn = 0; m_first = 0; m_owner_pf = 0; m_last_pf = -1000;
        cache_yumi = 0;
        set_in(0, 0, 0, 1, 0, 0);
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        // Reset state
        tick(0);
        check_eq("rst_v", 64'(s_v), 64'd0);
        check_eq("rst_owner", 64'(owner_pftch), 64'd0);

        // Demand only: accept t0, metadata t1, last t5, ready t6
        set_in(1, 0, 0, 1, 0, 0); tick(1);
        check_eq("dem_yumi_t0", 64'(s_dy), 64'd1);
        set_in(0, 0, 0, 1, 0, 0); tick(0);
        repeat (3) tick(0);
        set_in(0, 0, 0, 1, 0, 1); tick(0);
        check_eq("dem_last_t5", 64'(s_dl), 64'd1);
        set_in(1, 0, 0, 1, 0, 0); tick(0);
        check_eq("dem_ready_t6", 64'(s_v), 64'd1);

        // Simultaneous demand + prefetch: demand wins, prefetch after demand's last
        set_in(1, 1, 0, 1, 0, 0); tick(1);
        check_eq("sim_req", 64'(s_req), 64'(demand_req));
        check_eq("sim_pyumi", 64'(s_py), 64'd0);
        set_in(0, 1, 0, 1, 0, 0); tick(0); tick(0);
        check_eq("sim_pf_wait", 64'(s_v), 64'd0);
        set_in(0, 1, 0, 1, 0, 1); tick(0);
        set_in(0, 1, 0, 1, 0, 0); tick(1);
        check_eq("sim_pf_grant", 64'(s_py), 64'd1);

        // Back-to-back prefetch: granted t0, last t3, next v_o at t4
        tick(0); tick(0);
        set_in(0, 1, 0, 1, 0, 1); tick(0);
        set_in(0, 1, 0, 1, 0, 0); tick(1);
        check_eq("b2b_v_t4", 64'(s_v), 64'd1);
        // Early last in the metadata cycle still respects the cooldown
        set_in(0, 1, 0, 1, 0, 1); tick(0);
        set_in(0, 1, 0, 1, 0, 0); tick(0);
        check_eq("cool_t2", 64'(s_v), 64'd0);
        tick(0);
        check_eq("cool_t3", 64'(s_v), 64'd0);
        tick(0);
        check_eq("cool_t4", 64'(s_v), 64'd1);

        // Prefetch gating by lock and credits; demand still forwarded
        set_in(0, 1, 1, 1, 0, 0); tick(0);
        check_eq("gate_lock", 64'(s_v), 64'd0);
        set_in(0, 1, 0, 0, 0, 0); tick(0);
        check_eq("gate_cred", 64'(s_v), 64'd0);
        set_in(1, 1, 1, 0, 0, 0); tick(0);
        check_eq("gate_demand", 64'(s_v), 64'd1);

        // Prefetch completion routing
        set_in(0, 1, 0, 1, 0, 0); tick(1);
        set_in(0, 0, 0, 1, 1, 0); tick(0);
        check_eq("rt_pcrit", 64'(s_pc), 64'd1);
        check_eq("rt_dcrit", 64'(s_dc), 64'd0);
        set_in(0, 0, 0, 1, 0, 1); tick(0);
        check_eq("rt_plast", 64'(s_pl), 64'd1);
        check_eq("rt_dlast", 64'(s_dl), 64'd0);

        // Reset in e_busy, stray last afterwards, then a normal demand grant
        set_in(1, 0, 0, 1, 0, 0); tick(1);
        set_in(0, 0, 0, 1, 0, 0); tick(0); tick(0);
        reset = 1; tick(0); reset = 0;
        set_in(0, 0, 0, 1, 1, 1); tick(0);
        check_eq("rst_busy_dlast", 64'(s_dl), 64'd0);
        check_eq("rst_busy_plast", 64'(s_pl), 64'd0);
        set_in(1, 0, 0, 1, 0, 0); tick(1);
        check_eq("rst_busy_regrant", 64'(s_dy), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 3) == 0, ($urandom % 2) == 0, ($urandom % 5) == 0,
                   ($urandom % 10) < 7, ($urandom % 4) == 0, ($urandom % 4) == 0);
            demand_meta_v = 1'($urandom);
            pftch_meta_v  = 1'($urandom);
            reset = (($urandom % 150) == 0);
            tick(($urandom % 2) == 0);
            reset = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
